// File: rtl/vedic_mult_pipe.sv
// Pipelined Urdhva-Tiryagbhyam multiplier. Operands are reduced to magnitudes
// at the input. Rank 1 registers every 2x2 partial product. Each later rank
// merges groups of four sub-products into products of twice the width. The
// final rank reapplies the sign. Valid, tag and the sign flag move through
// the pipeline alongside the data.
//
// Handshake: a beat is accepted when in_valid_i && in_ready_o. A result is
// transferred when out_valid_o && out_ready_i. Stall is global: a result
// waiting at the output freezes every rank, and in_ready_o drops in the same
// cycle. Bubbles are not squeezed out.
module vedic_mult_pipe #(
  parameter int N     = 8,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [N-1:0]     in_a_i,
  input  logic [N-1:0]     in_b_i,
  input  logic             in_signed_i,
  input  logic [TAG_W-1:0] in_tag_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [2*N-1:0]   out_p_o,
  output logic [TAG_W-1:0] out_tag_o
);
  localparam int LAT = $clog2(N);

  logic         stall;
  logic         advance;
  logic         accept;
  logic [N-1:0] mag_a;
  logic [N-1:0] mag_b;
  logic         neg_in;

  // Index r holds rank r+1. The sign flag is consumed by the last rank, so
  // it is carried only through ranks 1..LAT-1.
  logic             valid_q [LAT];
  logic [TAG_W-1:0] tag_q   [LAT];
  logic             neg_q   [LAT-1];

  assign stall      = out_valid_o && !out_ready_i;
  assign advance    = !stall;
  assign in_ready_o = advance;
  assign accept     = in_valid_i && advance;

  // Strip the signs. The magnitude of the most negative value still fits N bits.
  always_comb begin
    mag_a  = in_a_i;
    mag_b  = in_b_i;
    neg_in = 1'b0;
    if (in_signed_i) begin
      if (in_a_i[N-1]) mag_a = -in_a_i;
      if (in_b_i[N-1]) mag_b = -in_b_i;
      neg_in = in_a_i[N-1] ^ in_b_i[N-1];
    end
  end

  // Control pipeline: valid, tag and sign flag advance together unless stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < LAT; r++) begin
        valid_q[r] <= 1'b0;
        tag_q[r]   <= '0;
      end
      for (int r = 0; r < LAT - 1; r++) neg_q[r] <= 1'b0;
    end else if (advance) begin
      valid_q[0] <= in_valid_i;
      if (accept) begin
        tag_q[0] <= in_tag_i;
        neg_q[0] <= neg_in;
      end
      for (int r = 1; r < LAT; r++) begin
        valid_q[r] <= valid_q[r-1];
        tag_q[r]   <= tag_q[r-1];
      end
      for (int r = 1; r < LAT - 1; r++) neg_q[r] <= neg_q[r-1];
    end
  end

  for (genvar k = 1; k <= LAT; k++) begin : g_rank
    localparam int W  = 1 << k;  // operand slice width handled at this rank
    localparam int M  = N / W;   // slices per operand
    localparam int NB = M * M;   // products held at this rank

    logic [2*W-1:0] pp_d [NB];
    logic [2*W-1:0] pp_q [NB];
    logic           load;

    // Rank 1 captures only accepted beats. Later ranks move on every unstalled cycle.
    assign load = (k == 1) ? accept : advance;

    if (k == 1) begin : g_leaf
      // Product of slice i of a with slice j of b, each slice 2 bits wide.
      always_comb begin
        for (int i = 0; i < M; i++) begin
          for (int j = 0; j < M; j++) begin
            pp_d[i*M+j] = {2'b00, mag_a[2*i +: 2]} * {2'b00, mag_b[2*j +: 2]};
          end
        end
      end
    end else begin : g_merge
      localparam int H  = W / 2;  // width of the sub-operands being merged
      localparam int MP = 2 * M;  // slices per operand at the previous rank
      // Merge the four sub-products: lo*lo + (hi*lo + lo*hi) << H + hi*hi << W.
      always_comb begin
        for (int i = 0; i < M; i++) begin
          for (int j = 0; j < M; j++) begin
            pp_d[i*M+j] =  (2*W)'(g_rank[k-1].pp_q[(2*i)*MP + 2*j])
                        + ((2*W)'(g_rank[k-1].pp_q[(2*i+1)*MP + 2*j]) << H)
                        + ((2*W)'(g_rank[k-1].pp_q[(2*i)*MP + 2*j+1]) << H)
                        + ((2*W)'(g_rank[k-1].pp_q[(2*i+1)*MP + 2*j+1]) << W);
            if (k == LAT && neg_q[LAT-2]) pp_d[i*M+j] = -pp_d[i*M+j];
          end
        end
      end
    end

    // Data register for this rank. It holds its value while the pipeline is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pp_q <= '{default: '0};
      else if (load) pp_q <= pp_d;
    end
  end

  assign out_valid_o = valid_q[LAT-1];
  assign out_tag_o   = tag_q[LAT-1];
  assign out_p_o     = g_rank[LAT].pp_q[0];

endmodule

// File: tb/tb_vedic_mult_pipe.sv
// Bench for vedic_mult_pipe. Four instances (N = 4, 8, 16, 32) share one
// stimulus bus. Only the selected instance receives beats and sees
// out_ready. A monitor pushes the expected product when a beat is accepted.
// It pops and compares that product when the instance emits a result.
module tb_vedic_mult_pipe;
  localparam int TAG_W = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- shared stimulus ----------------
  logic [31:0]      a, b;
  logic             sgn;
  logic [TAG_W-1:0] tag;
  logic             valid;
  logic             ordy;
  int               sel;          // 0:N=4 1:N=8 2:N=16 3:N=32
  int               cur_n, cur_lat;
  bit               rand_rdy;
  int               rdy_pct;
  bit               use_dir;
  logic [63:0]      dir_exp;

  assign cur_n   = 4 << sel;
  assign cur_lat = sel + 2;

  // ---------------- DUT instances ----------------
  logic rdy4, ov4, rdy8, ov8, rdy16, ov16, rdy32, ov32;
  logic [7:0]  p4;
  logic [15:0] p8;
  logic [31:0] p16;
  logic [63:0] p32;
  logic [TAG_W-1:0] tg4, tg8, tg16, tg32;

  vedic_mult_pipe #(.N(4), .TAG_W(TAG_W)) u_n4 (
    .clk(clk), .rst_n(rst_n), .in_valid_i(valid && (sel == 0)), .in_ready_o(rdy4),
    .in_a_i(a[3:0]), .in_b_i(b[3:0]), .in_signed_i(sgn), .in_tag_i(tag),
    .out_valid_o(ov4), .out_ready_i((sel == 0) ? ordy : 1'b1), .out_p_o(p4), .out_tag_o(tg4));
  vedic_mult_pipe #(.N(8), .TAG_W(TAG_W)) u_n8 (
    .clk(clk), .rst_n(rst_n), .in_valid_i(valid && (sel == 1)), .in_ready_o(rdy8),
    .in_a_i(a[7:0]), .in_b_i(b[7:0]), .in_signed_i(sgn), .in_tag_i(tag),
    .out_valid_o(ov8), .out_ready_i((sel == 1) ? ordy : 1'b1), .out_p_o(p8), .out_tag_o(tg8));
  vedic_mult_pipe #(.N(16), .TAG_W(TAG_W)) u_n16 (
    .clk(clk), .rst_n(rst_n), .in_valid_i(valid && (sel == 2)), .in_ready_o(rdy16),
    .in_a_i(a[15:0]), .in_b_i(b[15:0]), .in_signed_i(sgn), .in_tag_i(tag),
    .out_valid_o(ov16), .out_ready_i((sel == 2) ? ordy : 1'b1), .out_p_o(p16), .out_tag_o(tg16));
  vedic_mult_pipe #(.N(32), .TAG_W(TAG_W)) u_n32 (
    .clk(clk), .rst_n(rst_n), .in_valid_i(valid && (sel == 3)), .in_ready_o(rdy32),
    .in_a_i(a), .in_b_i(b), .in_signed_i(sgn), .in_tag_i(tag),
    .out_valid_o(ov32), .out_ready_i((sel == 3) ? ordy : 1'b1), .out_p_o(p32), .out_tag_o(tg32));

  logic             cur_rdy, cur_ov;
  logic [63:0]      cur_p;
  logic [TAG_W-1:0] cur_tag;
  always_comb begin
    cur_rdy = rdy4; cur_ov = ov4; cur_p = 64'(p4); cur_tag = tg4;
    case (sel)
      1: begin cur_rdy = rdy8;  cur_ov = ov8;  cur_p = 64'(p8);  cur_tag = tg8;  end
      2: begin cur_rdy = rdy16; cur_ov = ov16; cur_p = 64'(p16); cur_tag = tg16; end
      3: begin cur_rdy = rdy32; cur_ov = ov32; cur_p = p32;      cur_tag = tg32; end
      default: ;
    endcase
  end

  // ---------------- reference model and check helper ----------------
  int checks = 0;
  int failures = 0;

  function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y,
                                          input logic s, input int n);
    longint sx, sy, p;
    logic [63:0] m;
    sx = longint'(x) & ((64'sd1 <<< n) - 1);
    sy = longint'(y) & ((64'sd1 <<< n) - 1);
    if (s && x[n-1]) sx = sx - (64'sd1 <<< n);
    if (s && y[n-1]) sy = sy - (64'sd1 <<< n);
    p = sx * sy;
    m = p;
    if (n < 32) m = m & ((64'd1 << (2 * n)) - 1);
    return m;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (N=%0d cyc=%0d)", name, act, exp, cur_n, cyc);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [63:0]      exp_q[$];
  logic [TAG_W-1:0] exp_tag_q[$];
  int               acc_cyc_q[$];
  int               acc_stall_q[$];
  int               stall_cnt = 0;
  bit               hold_pend = 0;
  logic [63:0]      hold_p;
  logic [TAG_W-1:0] hold_tag;

  // The monitor runs on the falling edge, where every bench input is stable.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_pend = 0;
    end else begin
      check("in_ready_rule", 64'(cur_rdy), 64'(!(cur_ov && !ordy)));
      if (hold_pend) begin
        check("hold_valid", 64'(cur_ov), 64'd1);
        check("hold_p", cur_p, hold_p);
        check("hold_tag", 64'(cur_tag), 64'(hold_tag));
      end
      hold_pend = cur_ov && !ordy;
      hold_p    = cur_p;
      hold_tag  = cur_tag;
      if (cur_ov && !ordy) stall_cnt++;
      if (valid && cur_rdy) begin
        exp_q.push_back(use_dir ? dir_exp : ref_mul(a, b, sgn, cur_n));
        exp_tag_q.push_back(tag);
        acc_cyc_q.push_back(cyc + 1);
        acc_stall_q.push_back(stall_cnt);
      end
      if (cur_ov && ordy) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL spurious_beat: got p=%0h tag=%0h expected no beat (N=%0d cyc=%0d)",
                   cur_p, cur_tag, cur_n, cyc);
        end else begin
          int t0, s0;
          t0 = acc_cyc_q.pop_front();
          s0 = acc_stall_q.pop_front();
          check("product", cur_p, exp_q.pop_front());
          check("tag", 64'(cur_tag), 64'(exp_tag_q.pop_front()));
          check("latency", 64'(cyc - t0), 64'(cur_lat - 1 + (stall_cnt - s0)));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) ordy = ($urandom_range(0, 99) < rdy_pct);
  endtask

  task automatic send(input logic [31:0] ta, input logic [31:0] tb_v, input logic ts,
                      input logic [TAG_W-1:0] tt);
    bit acc;
    int guard;
    a = ta; b = tb_v; sgn = ts; tag = tt; valid = 1'b1;
    acc = 0;
    guard = 0;
    while (!acc && guard < 1000) begin
      @(negedge clk);
      acc = cur_rdy;
      tick();
      guard++;
    end
    if (!acc) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: got no accept in %0d cycles expected accept", guard);
    end
    valid = 1'b0;
  endtask

  task automatic send_exp(input logic [31:0] ta, input logic [31:0] tb_v, input logic ts,
                          input logic [TAG_W-1:0] tt, input logic [63:0] e);
    use_dir = 1;
    dir_exp = e;
    send(ta, tb_v, ts, tt);
    use_dir = 0;
  endtask

  task automatic idle(input int n);
    valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    valid = 1'b0;
    while (exp_q.size() != 0 && guard < 2000) begin
      tick();
      guard++;
    end
    check("drain_empty", 64'(exp_q.size()), 64'd0);
    rand_rdy = 0;
    ordy = 1'b1;
    idle(2);
  endtask

  function automatic logic [31:0] rand_op(input int n);
    logic [31:0] mask;
    mask = (n == 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 1);
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return mask;
      2: return 32'd1 << (n - 1);
      3: return mask >> 1;
      default: return $urandom() & mask;
    endcase
  endfunction

  task automatic random_beats(input int count, input bit gaps);
    for (int i = 0; i < count; i++) begin
      send(rand_op(cur_n), rand_op(cur_n), 1'($urandom_range(0, 1)), TAG_W'($urandom()));
      if (gaps && $urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 1'b0; valid = 1'b0; ordy = 1'b1; sel = 0; rand_rdy = 0; rdy_pct = 100;
    use_dir = 0; dir_exp = '0; a = '0; b = '0; sgn = 1'b0; tag = '0;
    repeat (3) @(posedge clk);
    #1;
    // Reset values of every instance
    for (int s = 0; s < 4; s++) begin
      sel = s;
      #1;
      check("rst_out_valid", 64'(cur_ov), 64'd0);
      check("rst_out_p", cur_p, 64'd0);
      check("rst_out_tag", 64'(cur_tag), 64'd0);
      check("rst_in_ready", 64'(cur_rdy), 64'd1);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);

    // N=8 unsigned max*max, then signed corners back to back
    sel = 1;
    send_exp(32'hFF, 32'hFF, 1'b0, 4'd3, 64'hFE01);
    idle(5);
    send_exp(32'h80, 32'h80, 1'b1, 4'd1, 64'h4000);
    send_exp(32'hFF, 32'h7F, 1'b1, 4'd2, 64'hFF81);
    send_exp(32'h80, 32'h7F, 1'b1, 4'd5, 64'hC080);
    drain();

    // N=4 signed -8*7, then the same bits unsigned
    sel = 0;
    send_exp(32'h8, 32'h7, 1'b1, 4'd6, 64'hC8);
    send_exp(32'h8, 32'h7, 1'b0, 4'd7, 64'h38);
    drain();

    // N=8 backpressure with random beats and gaps
    sel = 1;
    rand_rdy = 1; rdy_pct = 50;
    random_beats(10, 1);
    random_beats(40, 0);
    drain();

    // N=16 reset while beats are in flight
    sel = 2;
    send(32'h1234, 32'hABCD, 1'b0, 4'd1);
    send(32'hFFFF, 32'h8000, 1'b1, 4'd2);
    send(32'h7FFF, 32'h7FFF, 1'b1, 4'd3);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    exp_q.delete(); exp_tag_q.delete(); acc_cyc_q.delete(); acc_stall_q.delete();
    #1;
    check("midrst_out_valid", 64'(cur_ov), 64'd0);
    check("midrst_out_p", cur_p, 64'd0);
    check("midrst_in_ready", 64'(cur_rdy), 64'd1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("no_stale_beat", 64'(cur_ov), 64'd0);
    end
    random_beats(20, 1);
    drain();

    // N=32 random regression, out_ready high about 70% of cycles
    sel = 3;
    rand_rdy = 1; rdy_pct = 70;
    random_beats(10000, 0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
